// File: rtl/mux4_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the select through channels 0..3 with a
// programmable dwell, samples the mux output once per channel and hands the word downstream.
module mux4_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_in,
  input  logic       y_in,
  input  logic       ready_in,
  output logic [1:0] sel_out,
  output logic       busy_out,
  output logic [3:0] data_out,
  output logic       valid_out,
  output logic [1:0] dbg_state
);

  // Output handshake: data_out is offered while valid_out=1 and stays frozen until
  // an edge with valid_out && ready_in; ready_in while valid_out=0 has no effect.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       shadow_q, shadow_n;
  logic [1:0]       sel_n;
  logic             busy_n;
  logic [3:0]       data_n;
  logic             valid_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      sel_out   <= '0;
      busy_out  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      shadow_q  <= shadow_n;
      sel_out   <= sel_n;
      busy_out  <= busy_n;
      data_out  <= data_n;
      valid_out <= valid_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    shadow_n = shadow_q;
    sel_n    = sel_out;
    data_n   = data_out;
    valid_n  = valid_out;
    case (state_q)
      IDLE: begin
        valid_n = 1'b0;
        sel_n   = 2'd0;
        if (start_in) begin
          state_n = SCAN;
          cnt_n   = '0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST) begin
          cnt_n = '0;
          case (sel_out)
            2'd0: begin shadow_n[0] = y_in; sel_n = 2'd1; end
            2'd1: begin shadow_n[1] = y_in; sel_n = 2'd2; end
            2'd2: begin shadow_n[2] = y_in; sel_n = 2'd3; end
            default: begin
              // channel 3 goes straight into the word; the shadow only holds 0..2
              data_n  = {y_in, shadow_q};
              valid_n = 1'b1;
              sel_n   = 2'd0;
              state_n = DONE;
            end
          endcase
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (valid_out && ready_in) begin
          valid_n = 1'b0;
          if (start_in) begin
            state_n = SCAN;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        sel_n   = 2'd0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: two instances (DWELL=2 and DWELL=1) each driving a
// behavioural 4:1 mux; expected words are built from which a_in bit is present at each sample cycle.
module tb_mux4_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_a, start_b, ready_a, ready_b;
  logic [3:0] a_in;
  logic [1:0] sel_a, sel_b, dbg_a, dbg_b;
  logic       busy_a, busy_b, valid_a, valid_b;
  logic [3:0] data_a, data_b;
  logic       y_a, y_b;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_word[2];

  always #5 clock = ~clock;

  assign y_a = a_in[sel_a];
  assign y_b = a_in[sel_b];

  mux4_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .start_in(start_a), .y_in(y_a), .ready_in(ready_a),
    .sel_out(sel_a), .busy_out(busy_a), .data_out(data_a), .valid_out(valid_a), .dbg_state(dbg_a)
  );

  mux4_scan_ctrl #(.DWELL(1), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .start_in(start_b), .y_in(y_b), .ready_in(ready_b),
    .sel_out(sel_b), .busy_out(busy_b), .data_out(data_b), .valid_out(valid_b), .dbg_state(dbg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] o_sel(input int which);
    return (which == 0) ? sel_a : sel_b;
  endfunction
  function automatic logic o_busy(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic o_valid(input int which);
    return (which == 0) ? valid_a : valid_b;
  endfunction
  function automatic logic [3:0] o_data(input int which);
    return (which == 0) ? data_a : data_b;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v; else start_b = v;
  endtask
  task automatic set_ready(input int which, input logic v);
    if (which == 0) ready_a = v; else ready_b = v;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic kick(input int which);
    set_start(which, 1'b1);
    set_ready(which, 1'b0);
    @(negedge clock);
    set_start(which, 1'b0);
  endtask

  task automatic body(input int which, input int change_at, input logic [3:0] change_val,
                      input bit rand_a, input bit rand_start);
    int d;
    logic [3:0] w;
    d = (which == 0) ? 2 : 1;
    w = 4'h0;
    for (int c = 0; c < 4 * d; c++) begin
      chk("scan_sel", 32'(o_sel(which)), 32'(c / d));
      chk("scan_busy", 32'(o_busy(which)), 32'd1);
      chk("scan_valid", 32'(o_valid(which)), 32'd0);
      if (rand_start) set_start(which, 1'($urandom_range(0, 1)));
      if (c == change_at) a_in = change_val;
      if (rand_a) a_in = 4'($urandom_range(0, 15));
      if (c % d == d - 1) w[c / d] = a_in[c / d];
      @(negedge clock);
    end
    set_start(which, 1'b0);
    chk("done_valid", 32'(o_valid(which)), 32'd1);
    chk("done_data", 32'(o_data(which)), 32'(w));
    chk("done_busy", 32'(o_busy(which)), 32'd1);
    chk("done_sel", 32'(o_sel(which)), 32'd0);
    exp_q.push_back(w);
  endtask

  task automatic hold(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      set_ready(which, 1'b0);
      set_start(which, 1'($urandom_range(0, 1)));
      @(negedge clock);
      chk("hold_valid", 32'(o_valid(which)), 32'd1);
      chk("hold_data", 32'(o_data(which)), 32'(exp_q[$]));
      chk("hold_sel", 32'(o_sel(which)), 32'd0);
      chk("hold_busy", 32'(o_busy(which)), 32'd1);
    end
    set_start(which, 1'b0);
  endtask

  task automatic handshake(input int which, input bit again);
    logic [3:0] w;
    set_ready(which, 1'b1);
    set_start(which, again);
    @(negedge clock);
    set_ready(which, 1'b0);
    set_start(which, 1'b0);
    w = exp_q.pop_front();
    chk("hs_valid", 32'(o_valid(which)), 32'd0);
    chk("hs_busy", 32'(o_busy(which)), 32'(again));
    chk("hs_data", 32'(o_data(which)), 32'(w));
    chk("hs_sel", 32'(o_sel(which)), 32'd0);
    last_word[which] = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit again;
    int which;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    a_in = 4'h0;
    last_word[0] = 4'h0; last_word[1] = 4'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_sel", 32'(o_sel(i)), 32'd0);
      chk("rst_busy", 32'(o_busy(i)), 32'd0);
      chk("rst_valid", 32'(o_valid(i)), 32'd0);
      chk("rst_data", 32'(o_data(i)), 32'd0);
    end

    // Basic scan, immediate acceptance
    a_in = 4'b1010;
    kick(0);
    body(0, -1, 4'h0, 1'b0, 1'b0);
    handshake(0, 1'b0);

    // Ready while idle must not disturb anything
    ready_a = 1'b1;
    @(negedge clock);
    ready_a = 1'b0;
    chk("idle_ready_valid", 32'(valid_a), 32'd0);
    chk("idle_ready_busy", 32'(busy_a), 32'd0);
    chk("idle_data", 32'(data_a), 32'(last_word[0]));

    // Backpressure with start toggling
    a_in = 4'b0110;
    kick(0);
    body(0, -1, 4'h0, 1'b0, 1'b1);
    hold(0, 5);
    // Back-to-back scan with a new input pattern
    a_in = 4'b0001;
    handshake(0, 1'b1);
    body(0, -1, 4'h0, 1'b0, 1'b0);
    handshake(0, 1'b0);

    // Reset while sel_out=2: partial word discarded
    kick(0);
    for (int c = 0; c < 4; c++) @(negedge clock);
    chk("pre_reset_sel", 32'(sel_a), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_sel", 32'(sel_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_data", 32'(data_a), 32'd0);
    last_word[0] = 4'h0; last_word[1] = 4'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk("post_rst_valid", 32'(valid_a), 32'd0);
      chk("post_rst_busy", 32'(busy_a), 32'd0);
    end

    // Single-cycle dwell
    a_in = 4'b1111;
    kick(1);
    body(1, -1, 4'h0, 1'b0, 1'b0);
    handshake(1, 1'b0);

    // Input changes during channel 2 before its sample cycle
    a_in = 4'b0000;
    kick(0);
    body(0, 4, 4'b1111, 1'b0, 1'b0);
    chk("midchange_word", 32'(data_a), 32'h0000_000c);
    handshake(0, 1'b0);

    // Randomized scans on either instance
    for (int n = 0; n < 10; n++) begin
      which = int'($urandom_range(0, 1));
      a_in = 4'($urandom_range(0, 15));
      kick(which);
      body(which, -1, 4'h0, 1'b1, 1'b1);
      hold(which, int'($urandom_range(0, 3)));
      again = 1'($urandom_range(0, 1));
      handshake(which, again);
      if (again) begin
        body(which, -1, 4'h0, 1'b1, 1'b0);
        handshake(which, 1'b0);
      end
      chk("rand_idle_a", 32'(data_a), 32'(last_word[0]));
      chk("rand_idle_b", 32'(data_b), 32'(last_word[1]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Scan controller that sits in front of and behind the 4:1 mux (mux4_1).
- Drives the mux select (sel_out -> sel_in) through channels 0..3, with a programmable dwell per channel.
- Samples the mux output (y_out -> y_in) once per channel and assembles the four samples into a 4-bit word.
- Presents the word downstream on a valid/ready handshake.

Parameters:
DWELL, 2, clock cycles spent on each select value; y_in is sampled on the last cycle; legal range 1..15
CNT_W, 4, width of the internal dwell counter; must hold DWELL-1

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start_in  input  1  request a scan; sampled only in IDLE or in DONE together with a completed handshake
y_in  input  1  mux output (connects to mux4_1 y_out)
ready_in  input  1  downstream ready to accept data_out
sel_out  output  2  mux select (connects to mux4_1 sel_in)
busy_out  output  1  high while in SCAN or DONE
data_out  output  4  assembled word; bit k = y_in sampled while sel_out==k
valid_out  output  1  data_out valid; held until accepted

Behaviour:
- Reset: one clock and a synchronous active-high reset. Reset takes priority over all other inputs at the clock edge.
  - Outputs after reset: state=IDLE, sel_out=0, busy_out=0, data_out=0, valid_out=0.
  - Internal: dwell counter=0, shadow register=0.
- FSM states: IDLE, SCAN, DONE. All outputs are registered.
- IDLE:
  - sel_out=0, busy_out=0, valid_out=0.
  - data_out retains the last accepted word.
  - start_in=1 -> SCAN; counter=0; sel_out=0.
- SCAN:
  - Each edge: if counter==DWELL-1, then capture shadow[sel_out] <= y_in, set counter=0, and increment sel_out. Otherwise counter+1.
  - On the capture with sel_out==3:
    - data_out <= {y_in, shadow[2:0]}
    - valid_out <= 1
    - sel_out <= 0
    - state -> DONE
  - start_in is ignored in SCAN.
- DONE:
  - valid_out=1, busy_out=1. data_out and sel_out=0 are held stable until the handshake.
  - Handshake: the word is transferred on any edge with valid_out && ready_in.
    - With start_in=0: -> IDLE, valid_out=0.
    - With start_in=1 on the same edge: -> SCAN directly, counter=0, valid_out=0 (back-to-back scans, no IDLE bubble).
  - ready_in=0: stay in DONE indefinitely; start_in is ignored.
- Latency:
  - start accepted at edge E0.
  - sel_out=k for cycles E0+k*DWELL .. E0+(k+1)*DWELL-1.
  - valid_out rises at edge E0+4*DWELL (8 cycles for DWELL=2).
- Sampling rule: y_in for channel k is the value present in the last dwell cycle of sel_out=k. This gives the mux DWELL-1 cycles of settle.
- Wrap-around: sel_out wraps 3->0 only via the DONE transition. It never counts past 3 within a scan.
- The shadow register is not cleared between scans; every bit is rewritten each scan.
- Reset mid-scan or in DONE: the partial word is discarded. data_out=0 and valid_out=0 on the reset edge; no handshake completes.
- ready_in high while valid_out=0: no effect.

Test Plan:
1. DWELL=2, mux4_1 connected with a_in=4'b1010, start_in pulsed 1 cycle -> sel_out sequence 0,0,1,1,2,2,3,3. valid_out rises 8 cycles after the start edge with data_out=4'b1010 and busy_out=1. ready_in=1 -> IDLE next edge.
2. Backpressure: complete a scan with a_in=4'b0110 and ready_in=0 for 5 cycles while start_in toggles -> valid_out stays 1, data_out stays 4'b0110, sel_out stays 0, no new scan. Raise ready_in -> valid_out=0 next edge.
3. Back-to-back: in DONE, assert ready_in=1 and start_in=1 on the same cycle with a_in changed to 4'b0001 -> next edge SCAN with sel_out=0 and valid_out=0. Second word 4'b0001 valid 8 cycles later.
4. Reset mid-scan: assert reset for 1 cycle while sel_out=2 -> on that edge sel_out=0, busy_out=0, valid_out=0, data_out=0. No valid_out follows without a new start_in.
5. DWELL=1 override, a_in=4'b1111 -> sel_out changes every cycle (0,1,2,3) and valid_out rises 4 cycles after the start edge with data_out=4'b1111.
6. a_in changed mid-scan from 4'b0000 to 4'b1111 while sel_out=2 (DWELL=2, before the sample cycle) -> data_out=4'b1100.
